// File: rtl/seven_seg_scan_decoder.sv
// Read-back monitor for the multiplexed 7-segment bus: recovers the hex value shown
// on each digit position once a pattern has been steady for STABLE_CYCLES samples.
module seven_seg_scan_decoder #(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic [6:0]              i_SEG,
    input  logic [NUM_DIGITS-1:0]   i_DIGIT_EN,
    output logic [3:0]              o_VALUE,
    output logic [IDX_W-1:0]        o_DIGIT_IDX,
    output logic                    o_VALID,
    output logic                    o_ERROR,
    output logic [4*NUM_DIGITS-1:0] o_VALUES,
    output logic [NUM_DIGITS-1:0]   o_BLANK
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HELD} state_t;

    state_t                state, state_nx;
    logic [7:0]            cnt, cnt_nx;
    logic [6:0]            smp_seg, prv_seg;
    logic [NUM_DIGITS-1:0] smp_en, prv_en;
    logic                  smp_onehot, changed, capture;
    logic [3:0]            dec_value;
    logic                  dec_legal, dec_blank;
    logic [IDX_W-1:0]      cap_idx;

    // The previous sample is the pattern being tracked; it is what gets captured.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            smp_seg <= '0;
            smp_en  <= '0;
            prv_seg <= '0;
            prv_en  <= '0;
        end else begin
            smp_seg <= i_SEG;
            smp_en  <= i_DIGIT_EN;
            prv_seg <= smp_seg;
            prv_en  <= smp_en;
        end
    end

    assign smp_onehot = $onehot(smp_en);
    assign changed    = (smp_seg != prv_seg) || (smp_en != prv_en);
    assign capture    = (state == S_TRACK) && (cnt == CNT_MAX);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            S_IDLE: begin
                state_nx = smp_onehot ? S_TRACK : S_IDLE;
                cnt_nx   = smp_onehot ? 8'd1 : 8'd0;
            end
            S_TRACK: begin
                if (capture && !changed) begin
                    state_nx = S_HELD;
                end else if (!changed) begin
                    cnt_nx = cnt + 8'd1;
                end else begin
                    state_nx = smp_onehot ? S_TRACK : S_IDLE;
                    cnt_nx   = smp_onehot ? 8'd1 : 8'd0;
                end
            end
            S_HELD: begin
                if (changed) begin
                    state_nx = smp_onehot ? S_TRACK : S_IDLE;
                    cnt_nx   = smp_onehot ? 8'd1 : 8'd0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    // Inverse of the binary-to-segment encoder; bit order is g..a.
    always_comb begin
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        dec_value = 4'h0;
        case (prv_seg)
            7'b0111111: dec_value = 4'h0;
            7'b0000110: dec_value = 4'h1;
            7'b1011011: dec_value = 4'h2;
            7'b1001111: dec_value = 4'h3;
            7'b1100110: dec_value = 4'h4;
            7'b1101101: dec_value = 4'h5;
            7'b1111101: dec_value = 4'h6;
            7'b0000111: dec_value = 4'h7;
            7'b1111111: dec_value = 4'h8;
            7'b1100111: dec_value = 4'h9;
            7'b1110111: dec_value = 4'hA;
            7'b1111100: dec_value = 4'hB;
            7'b1011000: dec_value = 4'hC;
            7'b1011110: dec_value = 4'hD;
            7'b1111001: dec_value = 4'hE;
            7'b1110001: dec_value = 4'hF;
            7'b0000000: begin
                dec_legal = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        cap_idx = '0;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (prv_en[n]) begin
                cap_idx = IDX_W'(n);
            end
        end
    end

    // Pulses default low every cycle, so each capture yields exactly one cycle high.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_VALUE     <= '0;
            o_DIGIT_IDX <= '0;
            o_VALID     <= 1'b0;
            o_ERROR     <= 1'b0;
            o_VALUES    <= '0;
            o_BLANK     <= '0;
        end else begin
            o_VALID <= 1'b0;
            o_ERROR <= 1'b0;
            if (capture) begin
                if (dec_legal) begin
                    o_VALUE     <= dec_value;
                    o_DIGIT_IDX <= cap_idx;
                    o_VALID     <= 1'b1;
                    for (int n = 0; n < NUM_DIGITS; n++) begin
                        if (prv_en[n]) begin
                            o_VALUES[4*n +: 4] <= dec_value;
                            o_BLANK[n]         <= 1'b0;
                        end
                    end
                end else if (dec_blank) begin
                    for (int n = 0; n < NUM_DIGITS; n++) begin
                        if (prv_en[n]) begin
                            o_BLANK[n] <= 1'b1;
                        end
                    end
                end else begin
                    o_ERROR     <= 1'b1;
                    o_DIGIT_IDX <= cap_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench for seven_seg_scan_decoder: directed vector table, hand-written
// timing/reset sequences, then random patterns checked against a run-length model.
module tb_seven_seg_scan_decoder;

    localparam int NUM_DIGITS    = 2;
    localparam int STABLE_CYCLES = 4;

    logic       i_CLK = 1'b0;
    logic       i_RST;
    logic [6:0] i_SEG;
    logic [1:0] i_DIGIT_EN;
    logic [3:0] o_VALUE;
    logic [0:0] o_DIGIT_IDX;
    logic       o_VALID;
    logic       o_ERROR;
    logic [7:0] o_VALUES;
    logic [1:0] o_BLANK;

    seven_seg_scan_decoder #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .i_CLK       (i_CLK),
        .i_RST       (i_RST),
        .i_SEG       (i_SEG),
        .i_DIGIT_EN  (i_DIGIT_EN),
        .o_VALUE     (o_VALUE),
        .o_DIGIT_IDX (o_DIGIT_IDX),
        .o_VALID     (o_VALID),
        .o_ERROR     (o_ERROR),
        .o_VALUES    (o_VALUES),
        .o_BLANK     (o_BLANK)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct {
        logic [1:0] en;
        logic [6:0] seg;
        int         hold;
        int         expValid;
        int         expError;
        logic [7:0] expValues;
        logic [1:0] expBlank;
        logic [3:0] expValue;
        logic [0:0] expIdx;
    } vec_t;

    // Segment pattern (g..a) for each hex value, indexed by the value.
    logic [6:0] segTable [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
        7'b1011000, 7'b1011110, 7'b1111001, 7'b1110001
    };

    vec_t vecs [13];
    int   errors = 0;
    int   checks = 0;
    int   validSeen;
    int   errorSeen;

    logic [8:0] lastX;
    int         runLen;
    logic       pendNextV, pendDueV;
    logic [8:0] pendNext, pendDue;
    logic       eValid, eError;
    logic [3:0] eValue;
    logic [0:0] eIdx;
    logic [7:0] eValues;
    logic [1:0] eBlank;

    function automatic logic [31:0] outBundle();
        return {15'd0, o_VALID, o_ERROR, o_VALUE, o_DIGIT_IDX, o_VALUES, o_BLANK};
    endfunction

    function automatic logic [31:0] expBundle();
        return {15'd0, eValid, eError, eValue, eIdx, eValues, eBlank};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #1;
        if (o_VALID) validSeen++;
        if (o_ERROR) errorSeen++;
        checkOutput("pulse_overlap", {31'd0, o_VALID & o_ERROR}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [6:0] seg, input int cycles);
        i_DIGIT_EN = en;
        i_SEG      = seg;
        repeat (cycles) tick();
    endtask

    task automatic doReset();
        i_RST      = 1'b1;
        i_DIGIT_EN = '0;
        i_SEG      = '0;
        repeat (2) tick();
        i_RST = 1'b0;
    endtask

    task automatic modelReset();
        lastX     = '0;
        runLen    = 0;
        pendNextV = 1'b0;
        pendDueV  = 1'b0;
        pendNext  = '0;
        pendDue   = '0;
        eValid    = 1'b0;
        eError    = 1'b0;
        eValue    = '0;
        eIdx      = '0;
        eValues   = '0;
        eBlank    = '0;
    endtask

    task automatic modelCapture(input logic [8:0] x);
        int d;
        int code;
        d    = x[8] ? 1 : 0;
        code = -1;
        for (int k = 0; k < 16; k++) begin
            if (segTable[k] == x[6:0]) code = k;
        end
        if (code >= 0) begin
            eValid           = 1'b1;
            eValue           = 4'(code);
            eIdx             = 1'(d);
            eValues[4*d +: 4] = 4'(code);
            eBlank[d]        = 1'b0;
        end else if (x[6:0] == 7'd0) begin
            eBlank[d] = 1'b1;
        end else begin
            eError = 1'b1;
            eIdx   = 1'(d);
        end
    endtask

    // A run of identical one-hot samples is captured once, two edges after it reaches
    // STABLE_CYCLES samples.
    task automatic modelEdge();
        logic [8:0] x;
        if (i_RST) begin
            modelReset();
        end else begin
            eValid = 1'b0;
            eError = 1'b0;
            if (pendDueV) modelCapture(pendDue);
            pendDueV  = pendNextV;
            pendDue   = pendNext;
            pendNextV = 1'b0;
            x = {i_DIGIT_EN, i_SEG};
            if (x == lastX) runLen++;
            else runLen = 1;
            lastX = x;
            if ($countones(i_DIGIT_EN) == 1 && runLen == STABLE_CYCLES) begin
                pendNextV = 1'b1;
                pendNext  = x;
            end
        end
    endtask

    task automatic randTick();
        @(posedge i_CLK);
        #1;
        modelEdge();
        checkOutput("random_outputs", outBundle(), expBundle());
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: still running at %0t, limit 2000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] rEn;
        logic [6:0] rSeg;
        int         r;
        int         hold;

        vecs[0]  = '{2'b01, 7'b1011011,  6, 1, 0, 8'h02, 2'b00, 4'h2, 1'b0};
        vecs[1]  = '{2'b10, 7'b1111001,  3, 0, 0, 8'h02, 2'b00, 4'h2, 1'b0};
        vecs[2]  = '{2'b10, 7'b0000111, 10, 1, 0, 8'h72, 2'b00, 4'h7, 1'b1};
        vecs[3]  = '{2'b01, 7'b1100110, 10, 1, 0, 8'h74, 2'b00, 4'h4, 1'b0};
        vecs[4]  = '{2'b01, 7'b1010101,  6, 0, 1, 8'h74, 2'b00, 4'h4, 1'b0};
        vecs[5]  = '{2'b11, 7'b0111111, 10, 0, 0, 8'h74, 2'b00, 4'h4, 1'b0};
        vecs[6]  = '{2'b00, 7'b0111111, 10, 0, 0, 8'h74, 2'b00, 4'h4, 1'b0};
        vecs[7]  = '{2'b10, 7'b0000000,  5, 0, 0, 8'h74, 2'b10, 4'h4, 1'b0};
        vecs[8]  = '{2'b10, 7'b1110111,  4, 1, 0, 8'hA4, 2'b00, 4'hA, 1'b1};
        vecs[9]  = '{2'b01, 7'b0000000,  4, 0, 0, 8'hA4, 2'b01, 4'hA, 1'b1};
        vecs[10] = '{2'b01, 7'b1111100,  4, 1, 0, 8'hAB, 2'b00, 4'hB, 1'b0};
        vecs[11] = '{2'b01, 7'b1111100,  4, 1, 0, 8'hAB, 2'b00, 4'hB, 1'b0};
        vecs[12] = '{2'b10, 7'b1110001,  8, 1, 0, 8'hFB, 2'b00, 4'hF, 1'b1};

        i_RST      = 1'b1;
        i_DIGIT_EN = '0;
        i_SEG      = '0;
        validSeen  = 0;
        errorSeen  = 0;
        #2;
        checkOutput("reset_state", outBundle(), 32'd0);
        doReset();

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            validSeen = 0;
            errorSeen = 0;
            applyStimulus(vecs[i].en, vecs[i].seg, vecs[i].hold);
            applyStimulus(2'b00, 7'd0, 6);
            checkOutput($sformatf("vec%0d_valid_pulses", i), 32'(validSeen), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_error_pulses", i), 32'(errorSeen), 32'(vecs[i].expError));
            checkOutput($sformatf("vec%0d_values", i), {24'd0, o_VALUES}, {24'd0, vecs[i].expValues});
            checkOutput($sformatf("vec%0d_blank", i), {30'd0, o_BLANK}, {30'd0, vecs[i].expBlank});
            checkOutput($sformatf("vec%0d_value", i), {28'd0, o_VALUE}, {28'd0, vecs[i].expValue});
            checkOutput($sformatf("vec%0d_idx", i), {31'd0, o_DIGIT_IDX}, {31'd0, vecs[i].expIdx});
        end

        $display("[TB] glitch sequence");
        validSeen = 0;
        errorSeen = 0;
        applyStimulus(2'b01, 7'b0000110, 3);
        applyStimulus(2'b01, 7'b1011011, 1);
        applyStimulus(2'b01, 7'b0000110, 3);
        applyStimulus(2'b00, 7'd0, 6);
        checkOutput("glitch_no_valid", 32'(validSeen), 32'd0);
        checkOutput("glitch_no_error", 32'(errorSeen), 32'd0);
        checkOutput("glitch_values", {24'd0, o_VALUES}, 32'h0000_00FB);
        applyStimulus(2'b01, 7'b0000110, 4);
        applyStimulus(2'b00, 7'd0, 6);
        checkOutput("after_glitch_valid", 32'(validSeen), 32'd1);
        checkOutput("after_glitch_values", {24'd0, o_VALUES}, 32'h0000_00F1);

        $display("[TB] reset during count");
        applyStimulus(2'b01, 7'b1111111, 3);
        i_RST = 1'b1;
        #1;
        checkOutput("reset_midcount", outBundle(), 32'd0);
        tick();
        i_RST     = 1'b0;
        validSeen = 0;
        applyStimulus(2'b01, 7'b1111111, 4);
        applyStimulus(2'b00, 7'd0, 6);
        checkOutput("post_reset_valid", 32'(validSeen), 32'd1);
        checkOutput("post_reset_value", {28'd0, o_VALUE}, 32'd8);
        checkOutput("post_reset_values", {24'd0, o_VALUES}, 32'h0000_0008);

        $display("[TB] capture latency and reset during pulse");
        doReset();
        i_DIGIT_EN = 2'b01;
        i_SEG      = 7'b1011011;
        for (int e = 0; e <= STABLE_CYCLES + 1; e++) begin
            @(posedge i_CLK);
            #1;
            checkOutput($sformatf("latency_valid_edge%0d", e), {31'd0, o_VALID},
                        (e == STABLE_CYCLES + 1) ? 32'd1 : 32'd0);
        end
        i_RST = 1'b1;
        #1;
        checkOutput("reset_midpulse", outBundle(), 32'd0);
        tick();

        $display("[TB] random patterns against reference model");
        modelReset();
        randTick();
        i_RST = 1'b0;
        rEn  = 2'b01;
        rSeg = 7'd0;
        for (int run = 0; run < 450; run++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                i_RST = 1'b1;
                randTick();
                i_RST = 1'b0;
            end else begin
                if (r >= 18) begin
                    r = $urandom_range(0, 99);
                    if (r < 75) rEn = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                    else if (r < 87) rEn = 2'b00;
                    else rEn = 2'b11;
                    r = $urandom_range(0, 99);
                    if (r < 60) rSeg = segTable[$urandom_range(0, 15)];
                    else if (r < 75) rSeg = 7'd0;
                    else rSeg = 7'($urandom);
                end
                i_DIGIT_EN = rEn;
                i_SEG      = rSeg;
                hold = $urandom_range(1, 7);
                repeat (hold) randTick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
